// File: rtl/switch_bounce_gen_pkg.sv
// Shared definitions for the switch bounce emulator: FSM encoding and LFSR step.
package switch_bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    // Right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : {LFSR_W{1'b0}});
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; reusable pseudo-random source for stimulus blocks.
module lfsr16
    import switch_bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    // An all-zero seed would lock the register up, so it is replaced by 1.
    localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_VAL;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: drives a bouncy level toward a commanded target,
// with LFSR-spaced bounce edges followed by a stable settle period.
module switch_bounce_gen
    import switch_bounce_gen_pkg::*;
#(
    parameter logic [23:0] BOUNCE_CYCLES = 24'd20000,
    parameter logic [23:0] SETTLE_CYCLES = 24'd1000,
    parameter int          HOLD_BITS     = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_level,
    output logic        cmd_ready,
    output logic        switch_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] edge_count
);

    state_t                r_state;
    logic                  r_switch;
    logic                  r_target;
    logic                  r_done;
    logic [15:0]           r_edge_cnt;
    logic [HOLD_BITS-1:0]  r_hold;
    logic [23:0]           r_bounce_cnt;
    logic [23:0]           r_settle_cnt;

    state_t                w_state_nx;
    logic                  w_switch_nx;
    logic                  w_target_nx;
    logic                  w_done_nx;
    logic [15:0]           w_edge_nx;
    logic [HOLD_BITS-1:0]  w_hold_nx;
    logic [23:0]           w_bounce_nx;
    logic [23:0]           w_settle_nx;
    logic                  w_accept;
    logic [15:0]           w_lfsr;
    logic                  w_lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    // Only the low slice sets hold times; the upper bits just carry the sequence.
    assign w_lfsr_unused = ^w_lfsr;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    always_comb begin
        w_state_nx  = r_state;
        w_switch_nx = r_switch;
        w_target_nx = r_target;
        w_done_nx   = 1'b0;
        w_edge_nx   = r_edge_cnt;
        w_hold_nx   = r_hold;
        w_bounce_nx = r_bounce_cnt;
        w_settle_nx = r_settle_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_level == r_switch) begin
                        w_edge_nx = 16'd0;
                        w_done_nx = 1'b1;
                    end else begin
                        w_target_nx = cmd_level;
                        w_switch_nx = cmd_level;
                        w_edge_nx   = 16'd1;
                        w_hold_nx   = w_lfsr[HOLD_BITS-1:0];
                        w_bounce_nx = 24'd0;
                        w_settle_nx = 24'd0;
                        if (BOUNCE_CYCLES != 24'd0) begin
                            w_state_nx = ST_BOUNCE;
                        end else if (SETTLE_CYCLES != 24'd0) begin
                            w_state_nx = ST_SETTLE;
                        end else begin
                            w_done_nx = 1'b1;
                        end
                    end
                end
            end

            ST_BOUNCE: begin
                w_bounce_nx = r_bounce_cnt + 24'd1;
                // Last window cycle forces the target regardless of the hold timer.
                if (r_bounce_cnt == BOUNCE_CYCLES - 24'd1) begin
                    w_switch_nx = r_target;
                    if (r_switch != r_target) begin
                        w_edge_nx = sat_inc16(r_edge_cnt);
                    end
                    if (SETTLE_CYCLES != 24'd0) begin
                        w_state_nx = ST_SETTLE;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end else if (r_hold == '0) begin
                    w_switch_nx = ~r_switch;
                    w_edge_nx   = sat_inc16(r_edge_cnt);
                    w_hold_nx   = w_lfsr[HOLD_BITS-1:0];
                end else begin
                    w_hold_nx = r_hold - HOLD_BITS'(1);
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_CYCLES - 24'd1) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_settle_nx = r_settle_cnt + 24'd1;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_switch     <= INIT_LEVEL;
            r_target     <= INIT_LEVEL;
            r_done       <= 1'b0;
            r_edge_cnt   <= 16'd0;
            r_hold       <= '0;
            r_bounce_cnt <= 24'd0;
            r_settle_cnt <= 24'd0;
        end else begin
            r_state      <= w_state_nx;
            r_switch     <= w_switch_nx;
            r_target     <= w_target_nx;
            r_done       <= w_done_nx;
            r_edge_cnt   <= w_edge_nx;
            r_hold       <= w_hold_nx;
            r_bounce_cnt <= w_bounce_nx;
            r_settle_cnt <= w_settle_nx;
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign switch_out = r_switch;
    assign done       = r_done;
    assign edge_count = r_edge_cnt;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: command table, held-valid, mid-command reset, debouncer.
module tb_switch_bounce_gen;

    localparam int B  = 64;
    localparam int S  = 16;
    localparam int DB_THRESH = 20;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_level;
    logic        cmd_ready;
    logic        switch_out;
    logic        busy;
    logic        done;
    logic [15:0] edge_count;

    int n_pass;
    int n_total;
    int lfsr_err;
    int done_cnt;

    logic [15:0] m_lfsr;
    logic        db_out;
    int          db_cnt;
    int          db_changes;

    typedef struct {
        logic lvl;
        int   lat;
        logic bnc;
    } vec_t;

    vec_t vecs[5];

    switch_bounce_gen #(
        .BOUNCE_CYCLES (24'd64),
        .SETTLE_CYCLES (24'd16),
        .HOLD_BITS     (3),
        .LFSR_SEED     (16'hACE1),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_level  (cmd_level),
        .cmd_ready  (cmd_ready),
        .switch_out (switch_out),
        .busy       (busy),
        .done       (done),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Galois, mask B400, shifting right every cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (dut.w_lfsr !== m_lfsr || dut.w_lfsr == 16'h0000) lfsr_err++;
            if (done) done_cnt++;
        end
    end

    // Counter-based debouncer: follows the input once it is stable for DB_THRESH cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            db_out <= 1'b0;
            db_cnt <= 0;
        end else if (switch_out == db_out) begin
            db_cnt <= 0;
        end else if (db_cnt == DB_THRESH - 1) begin
            db_out     <= switch_out;
            db_cnt     <= 0;
            db_changes <= db_changes + 1;
        end else begin
            db_cnt <= db_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Issue one command at the current negedge and follow it to completion.
    task automatic run_cmd(input logic lvl, input int exp_lat, input logic bnc, input string tag);
        logic       pre, expv, prev;
        logic [2:0] h;
        int         lat, edges, toggles, run, max_run, wave_err, busy_err;
        int         exp_ec;
        pre = switch_out;
        check({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_level = lvl;
        h = m_lfsr[2:0];
        expv = lvl;
        edges = 1;
        prev = pre;
        toggles = 0; run = 0; max_run = 0; wave_err = 0; busy_err = 0; lat = -1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (switch_out != prev) begin
                toggles++;
                run = 1;
            end else begin
                run++;
            end
            prev = switch_out;
            if (bnc) begin
                if (k <= B && run > max_run) max_run = run;
                if (k <= B + S && busy !== 1'b1) busy_err++;
                if (switch_out !== ((k <= B) ? expv : lvl)) wave_err++;
                if (k < B) begin
                    if (h == 3'd0) begin
                        expv = ~expv;
                        edges++;
                        h = m_lfsr[2:0];
                    end else begin
                        h = h - 3'd1;
                    end
                end else if (k == B) begin
                    if (expv != lvl) edges++;
                    expv = lvl;
                end
            end else if (switch_out !== pre) begin
                wave_err++;
            end
            @(negedge clk);
        end
        exp_ec = bnc ? edges : 0;
        check({tag, "_done_latency"}, lat, exp_lat);
        check({tag, "_final_level"}, switch_out, lvl);
        check({tag, "_ready_at_done"}, cmd_ready, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_edge_count"}, edge_count, exp_ec);
        check({tag, "_waveform_errs"}, wave_err, 0);
        if (bnc) begin
            check({tag, "_busy_errs"}, busy_err, 0);
            check({tag, "_edge_count_odd"}, edge_count[0], 1);
            check({tag, "_edge_count_vs_toggles"}, edge_count, toggles);
            check({tag, "_max_run_le8"}, (max_run <= 8) ? 1 : 0, 1);
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_edge_count_hold"}, edge_count, exp_ec);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int k;
        logic l;
        clk = 1'b0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_level = 1'b0;
        n_pass = 0; n_total = 0; lfsr_err = 0; done_cnt = 0; db_changes = 0;

        vecs[0] = '{lvl: 1'b0, lat: 1,         bnc: 1'b0};
        vecs[1] = '{lvl: 1'b1, lat: 1 + B + S, bnc: 1'b1};
        vecs[2] = '{lvl: 1'b1, lat: 1,         bnc: 1'b0};
        vecs[3] = '{lvl: 1'b0, lat: 1 + B + S, bnc: 1'b1};
        vecs[4] = '{lvl: 1'b0, lat: 1,         bnc: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_switch_out", switch_out, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_edge_count", edge_count, 0);
        rst = 1'b0;
        base = done_cnt;
        repeat (10) @(negedge clk);
        check("idle_switch_out", switch_out, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_no_done", done_cnt - base, 0);
        check("idle_lfsr", lfsr_err, 0);

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].lvl, vecs[i].lat, vecs[i].bnc, $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // cmd_valid held high: second command must land exactly on the done cycle.
        l = switch_out;
        cmd_valid = 1'b1;
        cmd_level = ~l;
        @(negedge clk);
        base = 0;
        for (int j = 1; j <= B + S; j++) begin
            if (busy !== 1'b1 || done !== 1'b0) base++;
            if (j == 40) cmd_level = l;
            @(negedge clk);
        end
        check("held_busy_no_restart", base, 0);
        check("held_done_cycle", done, 1);
        check("held_ready_on_done", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_second_level", switch_out, l);
        check("held_second_busy", busy, 1);
        check("held_second_edges", edge_count, 1);
        k = 1;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("held_second_latency", k, B + S + 1);
        check("held_second_final", switch_out, l);
        repeat (2) @(negedge clk);

        // Reset in the middle of a bouncing command.
        cmd_valid = 1'b1;
        cmd_level = ~switch_out;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_switch_out", switch_out, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_edge_count", edge_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        repeat (100) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        check("midrst_idle_busy", busy, 0);
        run_cmd(1'b1, 1 + B + S, 1'b1, "post_rst_up");
        repeat (2) @(negedge clk);
        run_cmd(1'b0, 1 + B + S, 1'b1, "post_rst_down");

        // Debounced view must change exactly once per command.
        repeat (30) @(negedge clk);
        base = db_changes;
        run_cmd(1'b1, 1 + B + S, 1'b1, "db_up");
        repeat (30) @(negedge clk);
        check("db_up_changes", db_changes - base, 1);
        check("db_up_level", db_out, 1);
        base = db_changes;
        run_cmd(1'b0, 1 + B + S, 1'b1, "db_down");
        repeat (30) @(negedge clk);
        check("db_down_changes", db_changes - base, 1);
        check("db_down_level", db_out, 0);

        check("lfsr_model_match", lfsr_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
